// File: rtl/linescanner_line_scheduler_if.sv
// Host/sensor-side signal bundle for linescanner_line_scheduler.
// The master drives requests, configuration and sensor strobes; the slave (the scheduler) returns status.
interface linescanner_line_scheduler_if #(
    parameter int LINE_CNT_W = 12,
    parameter int PIX_CNT_W  = 12,
    parameter int GAP_W      = 16
);
    logic                  start;
    logic                  abort;
    logic [LINE_CNT_W-1:0] cfg_lines;
    logic [PIX_CNT_W-1:0]  cfg_pixels;
    logic [GAP_W-1:0]      cfg_gap;
    logic                  lval;
    logic                  pixel_valid;
    logic                  capture_enable;
    logic                  busy;
    logic [LINE_CNT_W-1:0] line_index;
    logic                  line_done;
    logic                  frame_done;
    logic                  timeout;
    logic                  pixel_count_error;

    modport master (
        output start, abort, cfg_lines, cfg_pixels, cfg_gap, lval, pixel_valid,
        input  capture_enable, busy, line_index, line_done, frame_done, timeout,
               pixel_count_error
    );

    modport slave (
        input  start, abort, cfg_lines, cfg_pixels, cfg_gap, lval, pixel_valid,
        output capture_enable, busy, line_index, line_done, frame_done, timeout,
               pixel_count_error
    );
endinterface

// File: rtl/linescanner_line_scheduler.sv
// Frame sequencer for the line-scanner capture path: gates capture per line, spaces lines, times out on missing lval.
// Define LINESCANNER_SCHED_PIXEL_CHECK_EN to build the sticky per-line pixel-count compare.
module linescanner_line_scheduler #(
    parameter int LINE_CNT_W     = 12,
    parameter int PIX_CNT_W      = 12,
    parameter int GAP_W          = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                          pixel_clock,
    input logic                          reset,
    linescanner_line_scheduler_if.slave  bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LVAL,
        CAPTURE,
        LINE_GAP
    } state_t;

    state_t                state;
    logic [LINE_CNT_W-1:0] shadow_lines;
    logic [GAP_W-1:0]      shadow_gap;
    logic [LINE_CNT_W-1:0] line_index_q;
    logic [PIX_CNT_W-1:0]  pix_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic                  cap_q;
    logic                  busy_q;
    logic                  line_done_q;
    logic                  frame_done_q;
    logic                  timeout_q;
    logic                  last_line;
`ifdef LINESCANNER_SCHED_PIXEL_CHECK_EN
    logic [PIX_CNT_W-1:0]  shadow_pixels;
    logic                  err_q;
`endif

    assign last_line = (line_index_q == shadow_lines - LINE_CNT_W'(1));

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shadow_lines <= '0;
            shadow_gap   <= '0;
            line_index_q <= '0;
            pix_cnt      <= '0;
            gap_cnt      <= '0;
            to_cnt       <= '0;
            cap_q        <= 1'b0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef LINESCANNER_SCHED_PIXEL_CHECK_EN
            shadow_pixels <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;

            // abort outranks every other transition, including a line end in the same cycle
            if (state != IDLE && bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                cap_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && bus.cfg_lines != '0) begin
                            shadow_lines <= bus.cfg_lines;
                            shadow_gap   <= bus.cfg_gap;
                            line_index_q <= '0;
`ifdef LINESCANNER_SCHED_PIXEL_CHECK_EN
                            shadow_pixels <= bus.cfg_pixels;
                            err_q         <= 1'b0;
`endif
                            busy_q <= 1'b1;
                            state  <= ARM;
                        end
                    end

                    ARM: begin
                        to_cnt <= '0;
                        cap_q  <= 1'b1;
                        state  <= WAIT_LVAL;
                    end

                    WAIT_LVAL: begin
                        if (bus.lval) begin
                            pix_cnt <= bus.pixel_valid ? PIX_CNT_W'(1) : '0;
                            state   <= CAPTURE;
                        end else if (to_cnt == TO_LAST) begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            cap_q     <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end

                    CAPTURE: begin
                        if (!bus.lval) begin
                            line_done_q <= 1'b1;
                            cap_q       <= 1'b0;
`ifdef LINESCANNER_SCHED_PIXEL_CHECK_EN
                            if (pix_cnt != shadow_pixels) begin
                                err_q <= 1'b1;
                            end
`endif
                            if (last_line) begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                line_index_q <= line_index_q + LINE_CNT_W'(1);
                                gap_cnt      <= shadow_gap;
                                state        <= LINE_GAP;
                            end
                        end else if (bus.pixel_valid && pix_cnt != '1) begin
                            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
                        end
                    end

                    LINE_GAP: begin
                        // gap counts down to and including 0, giving gap+1 cycles here
                        if (gap_cnt == '0) begin
                            state <= ARM;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cap_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.capture_enable = cap_q;
    assign bus.busy           = busy_q;
    assign bus.line_index     = line_index_q;
    assign bus.line_done      = line_done_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.timeout        = timeout_q;
`ifdef LINESCANNER_SCHED_PIXEL_CHECK_EN
    assign bus.pixel_count_error = err_q;
`else
    assign bus.pixel_count_error = 1'b0;
`endif
endmodule

// File: tb/tb_linescanner_line_scheduler.sv
// Scoreboard bench for linescanner_line_scheduler: stimulus queues expected line/frame/timeout events,
// a negedge monitor pops and compares them whenever the DUT pulses an event.
module tb_linescanner_line_scheduler;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    linescanner_line_scheduler_if bus ();

    linescanner_line_scheduler #(
        .LINE_CNT_W    (12),
        .PIX_CNT_W     (12),
        .GAP_W         (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pixel_clock(clk),
        .reset      (reset),
        .bus        (bus)
    );

    typedef struct packed {
        logic        ld;
        logic        fd;
        logic        to;
        logic        busy;
        logic        cap;
        logic [11:0] idx;
        logic        err;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_act;
    ev_t  mon_exp;
    logic exp_err;
    int   cur_pix;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic ev_t snap();
        ev_t s;
        s.ld   = bus.line_done;
        s.fd   = bus.frame_done;
        s.to   = bus.timeout;
        s.busy = bus.busy;
        s.cap  = bus.capture_enable;
        s.idx  = bus.line_index;
        s.err  = bus.pixel_count_error;
        return s;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && (bus.line_done || bus.frame_done || bus.timeout)) begin
            mon_act = snap();
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got %0h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("event", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cap();
        int n = 0;
        while (bus.capture_enable !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("cap_wait", 32'(bus.capture_enable), 32'd1);
    endtask

    task automatic measure_low(input int exp_cycles);
        int n = 0;
        while (bus.capture_enable !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk("cap_low_cycles", n, exp_cycles);
    endtask

    task automatic do_start(input int l, input int p, input int g);
        bus.cfg_lines  = 12'(l);
        bus.cfg_pixels = 12'(p);
        bus.cfg_gap    = 16'(g);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        if (l != 0) begin
            exp_err = 1'b0;
            cur_pix = p;
        end
    endtask

    task automatic send_line(input int npix, input int k, input int n);
        ev_t e;
        wait_cap();
`ifdef LINESCANNER_SCHED_PIXEL_CHECK_EN
        if (npix != cur_pix) exp_err = 1'b1;
`endif
        e.ld   = 1'b1;
        e.fd   = (k == n - 1);
        e.to   = 1'b0;
        e.busy = (k != n - 1);
        e.cap  = 1'b0;
        e.idx  = (k == n - 1) ? 12'(k) : 12'(k + 1);
        e.err  = exp_err;
        exp_q.push_back(e);
        for (int i = 0; i < npix; i++) begin
            bus.lval        = 1'b1;
            bus.pixel_valid = 1'b1;
            tick();
        end
        bus.lval        = 1'b0;
        bus.pixel_valid = 1'b0;
        tick();
    endtask

    task automatic frame_lines(input int n, input int pix, input int gap,
                               input int bad_line, input int bad_pix);
        for (int k = 0; k < n; k++) begin
            if (k > 0) measure_low(gap + 2);
            send_line((k == bad_line) ? bad_pix : pix, k, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        ev_t e;
        int  cnt;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_lines   = '0;
        bus.cfg_pixels  = '0;
        bus.cfg_gap     = '0;
        bus.lval        = 1'b0;
        bus.pixel_valid = 1'b0;
        exp_err         = 1'b0;
        cur_pix         = 0;

        @(negedge clk);
        chk("reset_outputs", 32'(snap()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // nominal 3-line frame, with start/arm latency checks
        do_start(3, 8, 4);
        @(negedge clk);
        chk("busy_after_start", 32'({bus.busy, bus.capture_enable}), 32'b10);
        @(negedge clk);
        chk("cap_after_arm", 32'(bus.capture_enable), 32'd1);
        frame_lines(3, 8, 4, -1, 0);
        @(negedge clk);
        chk("frame1_idle", 32'({bus.busy, bus.pixel_count_error}), 32'b00);
        tick();

        // short second line: error is sticky until the next accepted start
        do_start(3, 8, 4);
        frame_lines(3, 8, 4, 1, 7);
        repeat (3) tick();
        chk("err_sticky_idle", 32'(bus.pixel_count_error), 32'(exp_err));
        do_start(1, 8, 0);
        @(negedge clk);
        chk("err_cleared_on_start", 32'(bus.pixel_count_error), 32'd0);
        frame_lines(1, 8, 0, -1, 0);
        tick();

        // lval never rises
        do_start(2, 8, 4);
        e = '0;
        e.to = 1'b1;
        exp_q.push_back(e);
        wait_cap();
        cnt = 0;
        while (bus.timeout !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("timeout_latency", cnt, 16);
        tick();
        chk("after_timeout", 32'({bus.busy, bus.capture_enable}), 32'b00);

        // abort in the middle of line 1 of a 4-line frame
        do_start(4, 8, 4);
        send_line(8, 0, 4);
        measure_low(6);
        wait_cap();
        bus.lval        = 1'b1;
        bus.pixel_valid = 1'b1;
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort       = 1'b0;
        bus.lval        = 1'b0;
        bus.pixel_valid = 1'b0;
        chk("after_abort", 32'({bus.busy, bus.capture_enable}), 32'b00);
        repeat (5) tick();

        // full 4-line frame; a start during ARM with lines=1 must be ignored
        do_start(4, 8, 4);
        bus.cfg_lines = 12'd1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        frame_lines(4, 8, 4, -1, 0);
        tick();

        // zero gap: capture_enable low exactly 2 cycles between lines
        do_start(3, 4, 0);
        frame_lines(3, 4, 0, -1, 0);
        tick();

        // zero lines: start ignored
        do_start(0, 8, 4);
        @(negedge clk);
        chk("zero_lines_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        chk("zero_lines_idle", 32'({bus.busy, bus.capture_enable}), 32'b00);

        // asynchronous reset while in LINE_GAP
        do_start(3, 8, 10);
        send_line(8, 0, 3);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        chk("reset_in_gap", 32'(snap()), 32'd0);
        #10 reset = 1'b0;
        repeat (6) tick();
        chk("idle_after_reset", 32'(snap()), 32'd0);

        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
